// File: rtl/fft_spectrum_sink_if.sv
// ----------------------------------------------------------------------------
// fft_spectrum_sink_if: AXI4-Stream style FFT output bus ({Re,Im} beats, tlast). Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface fft_spectrum_sink_if #(
  parameter int DATA_W = 48
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/fft_spectrum_sink.sv
// ----------------------------------------------------------------------------
// fft_spectrum_sink: per-bin power into a double-buffered RAM with peak search. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fft_spectrum_sink #(
  parameter int FFT_LEN         = 1024,
  parameter int FFT_RE_IM_WIDTH = 24,
  parameter int PWR_WIDTH       = 32,
  parameter int PWR_SHIFT       = 14
) (
  input  logic                             clk_50m,
  input  logic                             rst_n,
  fft_spectrum_sink_if.slave               s_axis,
  output logic                             frame_valid,
  input  logic                             frame_ack,
  input  logic [$clog2(FFT_LEN/2)-1:0]     rd_addr,
  output logic [PWR_WIDTH-1:0]             rd_data,
  output logic [$clog2(FFT_LEN/2)-1:0]     peak_bin,
  output logic [PWR_WIDTH-1:0]             peak_pwr,
  output logic                             err_tlast_early,
  output logic                             err_tlast_missing
);

  localparam int NBINS  = FFT_LEN / 2;
  localparam int BIN_AW = $clog2(NBINS);
  localparam int CNT_W  = $clog2(FFT_LEN);
  localparam int W      = FFT_RE_IM_WIDTH;
  localparam int SQ_W   = 2 * W;
  localparam int SUM_W  = 2 * W + 1;

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(FFT_LEN - 1);

  localparam logic [1:0] c_FILL    = 2'd0;
  localparam logic [1:0] c_DRAIN   = 2'd1;
  localparam logic [1:0] c_WAIT    = 2'd2;
  localparam logic [1:0] c_PUBLISH = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  drain_q, drain_d;
  logic                  wr_bank_q, rd_bank_q;
  logic                  fv_q;
  logic                  tready_q;
  logic                  err_early_q, err_missing_q;

  logic                  s1_vld_q;
  logic [CNT_W-1:0]      s1_addr_q;
  logic [SQ_W-1:0]       re2_q, im2_q;

  logic [PWR_WIDTH-1:0]  max_pwr_q;
  logic [BIN_AW-1:0]     max_bin_q;
  logic [PWR_WIDTH-1:0]  peak_pwr_q;
  logic [BIN_AW-1:0]     peak_bin_q;
  logic [PWR_WIDTH-1:0]  rd_data_q;

  logic [PWR_WIDTH-1:0]  ram [2*NBINS];

  logic signed [W-1:0]    w_re, w_im;
  logic signed [SQ_W-1:0] w_re2, w_im2;
  logic                   w_accept, w_at_last, w_early, w_missing, w_publish;
  logic [SUM_W-1:0]       w_sum, w_shift;
  logic [PWR_WIDTH-1:0]   w_pwr;
  logic                   w_store;

  assign w_re  = s_axis.tdata[2*W-1:W];
  assign w_im  = s_axis.tdata[W-1:0];
  assign w_re2 = w_re * w_re;
  assign w_im2 = w_im * w_im;

  assign w_accept  = s_axis.tvalid & tready_q;
  assign w_at_last = (cnt_q == c_LAST_CNT);
  assign w_early   = w_accept & s_axis.tlast & ~w_at_last;
  assign w_missing = w_accept & w_at_last & ~s_axis.tlast;

  // S2: squares are non-negative, so zero-extend before summing
  assign w_sum   = SUM_W'(re2_q) + SUM_W'(im2_q);
  assign w_shift = w_sum >> PWR_SHIFT;
  assign w_pwr   = (|w_shift[SUM_W-1:PWR_WIDTH]) ? {PWR_WIDTH{1'b1}} : w_shift[PWR_WIDTH-1:0];
  assign w_store = s1_vld_q & ~s1_addr_q[CNT_W-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    w_publish = 1'b0;
    case (state_q)
      c_FILL: begin
        if (w_accept) begin
          if (w_at_last) begin
            state_d = c_DRAIN;
            drain_d = 1'b0;
          end else if (s_axis.tlast) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      c_DRAIN: begin
        if (drain_q) begin
          state_d = fv_q ? c_WAIT : c_PUBLISH;
        end else begin
          drain_d = 1'b1;
        end
      end
      c_WAIT: begin
        if (!fv_q) begin
          state_d = c_PUBLISH;
        end
      end
      c_PUBLISH: begin
        w_publish = 1'b1;
        cnt_d     = '0;
        state_d   = c_FILL;
      end
      default: state_d = c_FILL;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_FILL;
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      fv_q          <= 1'b0;
      tready_q      <= 1'b0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      re2_q         <= '0;
      im2_q         <= '0;
      max_pwr_q     <= '0;
      max_bin_q     <= '0;
      peak_pwr_q    <= '0;
      peak_bin_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      tready_q      <= (state_d == c_FILL);
      err_early_q   <= w_early;
      err_missing_q <= w_missing;

      // An aborted frame's final beat never enters the pipeline
      s1_vld_q  <= w_accept & ~w_early;
      s1_addr_q <= cnt_q;
      re2_q     <= w_re2;
      im2_q     <= w_im2;

      if (w_early) begin
        max_pwr_q <= '0;
        max_bin_q <= '0;
      end else if (w_store) begin
        if (s1_addr_q == '0) begin
          max_pwr_q <= '0;
          max_bin_q <= '0;
        end else if (w_pwr > max_pwr_q) begin
          max_pwr_q <= w_pwr;
          max_bin_q <= s1_addr_q[BIN_AW-1:0];
        end
      end

      if (w_publish) begin
        rd_bank_q  <= wr_bank_q;
        wr_bank_q  <= ~wr_bank_q;
        peak_pwr_q <= max_pwr_q;
        peak_bin_q <= max_bin_q;
        fv_q       <= 1'b1;
      end else if (frame_ack && fv_q) begin
        fv_q <= 1'b0;
      end

      rd_data_q <= ram[{rd_bank_q, rd_addr}];
    end
  end

  always_ff @(posedge clk_50m) begin
    if (w_store) begin
      ram[{wr_bank_q, s1_addr_q[BIN_AW-1:0]}] <= w_pwr;
    end
  end

  assign s_axis.tready     = tready_q;
  assign frame_valid       = fv_q;
  assign rd_data           = rd_data_q;
  assign peak_bin          = peak_bin_q;
  assign peak_pwr          = peak_pwr_q;
  assign err_tlast_early   = err_early_q;
  assign err_tlast_missing = err_missing_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_spectrum_sink.sv
// ----------------------------------------------------------------------------
// tb_fft_spectrum_sink: scoreboard bench for fft_spectrum_sink (shift 0 and default shift). Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fft_spectrum_sink;

  localparam int FFT_LEN = 1024;
  localparam int NB      = 512;
  localparam int AW      = 9;

  typedef struct {
    logic [8:0]       pb0;
    logic [31:0]      pp0;
    logic [8:0]       pb1;
    logic [31:0]      pp1;
    logic [3:0][8:0]  addr;
    logic [3:0][31:0] v0;
    logic [3:0][31:0] v1;
  } exp_t;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic          tvalid = 1'b0;
  logic          tlast  = 1'b0;
  logic [47:0]   tdata  = '0;
  logic          frame_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          fv0, fv1, ee0, ee1, em0, em1;
  logic [31:0]   rd0, rd1, pp0, pp1;
  logic [AW-1:0] pb0, pb1;

  fft_spectrum_sink_if #(.DATA_W(48)) ax0 ();
  fft_spectrum_sink_if #(.DATA_W(48)) ax1 ();

  assign ax0.tvalid = tvalid;
  assign ax0.tdata  = tdata;
  assign ax0.tlast  = tlast;
  assign ax1.tvalid = tvalid;
  assign ax1.tdata  = tdata;
  assign ax1.tlast  = tlast;

  fft_spectrum_sink #(.PWR_SHIFT(0)) dut0 (
    .clk_50m(clk_50m), .rst_n(rst_n), .s_axis(ax0),
    .frame_valid(fv0), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd0),
    .peak_bin(pb0), .peak_pwr(pp0), .err_tlast_early(ee0), .err_tlast_missing(em0)
  );

  fft_spectrum_sink dut1 (
    .clk_50m(clk_50m), .rst_n(rst_n), .s_axis(ax1),
    .frame_valid(fv1), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd1),
    .peak_bin(pb1), .peak_pwr(pp1), .err_tlast_early(ee1), .err_tlast_missing(em1)
  );

  int total = 0;
  int bad   = 0;
  int early_cnt = 0;
  int miss_cnt  = 0;

  logic signed [23:0] re_mem [FFT_LEN];
  logic signed [23:0] im_mem [FFT_LEN];
  exp_t sb [$];

  always @(negedge clk_50m) begin
    if (ee0) early_cnt++;
    if (em0) miss_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic logic [31:0] model_pwr(input logic signed [23:0] re,
                                            input logic signed [23:0] im, input int sh);
    logic signed [48:0] a, b, s;
    logic [48:0] t;
    a = re;
    b = im;
    s = a * a + b * b;
    t = s;
    t = t >> sh;
    if (|t[48:32]) return 32'hFFFF_FFFF;
    return t[31:0];
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < FFT_LEN; i++) begin
      re_mem[i] = '0;
      im_mem[i] = '0;
    end
  endtask

  task automatic push_expected(input logic [3:0][8:0] probes);
    exp_t e;
    logic [31:0] p;
    e.pp0 = '0; e.pb0 = '0; e.pp1 = '0; e.pb1 = '0;
    for (int b = 1; b < NB; b++) begin
      p = model_pwr(re_mem[b], im_mem[b], 0);
      if (p > e.pp0) begin e.pp0 = p; e.pb0 = 9'(b); end
      p = model_pwr(re_mem[b], im_mem[b], 14);
      if (p > e.pp1) begin e.pp1 = p; e.pb1 = 9'(b); end
    end
    e.addr = probes;
    for (int k = 0; k < 4; k++) begin
      e.v0[k] = model_pwr(re_mem[probes[k]], im_mem[probes[k]], 0);
      e.v1[k] = model_pwr(re_mem[probes[k]], im_mem[probes[k]], 14);
    end
    sb.push_back(e);
  endtask

  task automatic send_frame(input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      int t;
      t = 0;
      @(negedge clk_50m);
      while (ax0.tready !== 1'b1 && t < 200) begin
        @(negedge clk_50m);
        t++;
      end
      total++;
      if (ax0.tready !== 1'b1) begin
        bad++;
        $display("FAIL send_ready beat=%0d: tready=%b, want 1", i, ax0.tready);
        return;
      end
      tvalid = 1'b1;
      tdata  = {re_mem[i], im_mem[i]};
      tlast  = (i == last_at);
      @(posedge clk_50m);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (fv0 !== 1'b1 && cyc < limit) begin
      @(posedge clk_50m);
      #1;
      cyc++;
    end
  endtask

  task automatic check_published(input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard: queue size=0, want >0", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (fv0 !== 1'b1 || fv1 !== 1'b1) begin
      bad++; $display("FAIL %s_valid: got %b/%b, want 1/1", name, fv0, fv1);
    end
    total++;
    if (pb0 !== e.pb0 || pp0 !== e.pp0) begin
      bad++; $display("FAIL %s_peak_s0: got bin=%0d pwr=%0d, want bin=%0d pwr=%0d",
                      name, pb0, pp0, e.pb0, e.pp0);
    end
    total++;
    if (pb1 !== e.pb1 || pp1 !== e.pp1) begin
      bad++; $display("FAIL %s_peak_def: got bin=%0d pwr=%0d, want bin=%0d pwr=%0d",
                      name, pb1, pp1, e.pb1, e.pp1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_50m);
      rd_addr = e.addr[k];
      @(negedge clk_50m);
      total++;
      if (rd0 !== e.v0[k] || rd1 !== e.v1[k]) begin
        bad++; $display("FAIL %s_rd bin=%0d: got %h/%h, want %h/%h",
                        name, e.addr[k], rd0, rd1, e.v0[k], e.v1[k]);
      end
    end
  endtask

  task automatic ack_frame(input string name);
    @(negedge clk_50m);
    frame_ack = 1'b1;
    @(posedge clk_50m);
    #1;
    frame_ack = 1'b0;
    total++;
    if (fv0 !== 1'b0 || fv1 !== 1'b0) begin
      bad++; $display("FAIL %s_ack: frame_valid=%b/%b, want 0/0", name, fv0, fv1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    total++;
    if (ax0.tready !== 1'b0 || fv0 !== 1'b0 || rd0 !== 32'd0 || pb0 !== 9'd0 ||
        pp0 !== 32'd0 || ee0 !== 1'b0 || em0 !== 1'b0) begin
      bad++; $display("FAIL reset_state: tready=%b fv=%b rd=%h pb=%0d pp=%h ee=%b em=%b, want all 0",
                      ax0.tready, fv0, rd0, pb0, pp0, ee0, em0);
    end
    rst_n = 1'b1;
    @(posedge clk_50m);
    #1;
    total++;
    if (ax0.tready !== 1'b1 || ax1.tready !== 1'b1) begin
      bad++; $display("FAIL reset_release_tready: got %b/%b, want 1/1", ax0.tready, ax1.tready);
    end
  endtask

  task automatic test_single_bin();
    int cyc;
    clear_frame();
    re_mem[5] = 24'sd3;
    im_mem[5] = -24'sd4;
    push_expected({9'd5, 9'd0, 9'd4, 9'd6});
    send_frame(FFT_LEN, FFT_LEN - 1);
    wait_valid(20, cyc);
    total++;
    if (fv0 !== 1'b1 || cyc != 3) begin
      bad++; $display("FAIL single_latency: valid=%b after %0d cycles, want 1 after 3", fv0, cyc);
    end
    check_published("single");
    ack_frame("single");
  endtask

  task automatic test_saturation();
    int cyc;
    clear_frame();
    re_mem[7] = -24'sd8388608;
    im_mem[7] = -24'sd8388608;
    re_mem[2] = 24'sd1000;
    im_mem[2] = 24'sd1000;
    push_expected({9'd7, 9'd2, 9'd0, 9'd8});
    send_frame(FFT_LEN, FFT_LEN - 1);
    wait_valid(20, cyc);
    check_published("sat");
    ack_frame("sat");
  endtask

  task automatic test_tie_dc();
    int cyc;
    clear_frame();
    re_mem[0] = 24'sd6;  im_mem[0] = 24'sd8;
    re_mem[3] = -24'sd8; im_mem[3] = 24'sd6;
    re_mem[9] = 24'sd10; im_mem[9] = 24'sd0;
    push_expected({9'd3, 9'd9, 9'd0, 9'd7});
    send_frame(FFT_LEN, FFT_LEN - 1);
    wait_valid(20, cyc);
    check_published("tie");
    ack_frame("tie");
  endtask

  task automatic test_early_tlast();
    int cyc, e0, m0;
    e0 = early_cnt;
    m0 = miss_cnt;
    clear_frame();
    re_mem[100] = 24'sd1000;
    send_frame(501, 500);
    wait_valid(8, cyc);
    total++;
    if (fv0 !== 1'b0 || early_cnt - e0 != 1 || miss_cnt - m0 != 0) begin
      bad++; $display("FAIL early_abort: valid=%b early_pulses=%0d miss_pulses=%0d, want 0/1/0",
                      fv0, early_cnt - e0, miss_cnt - m0);
    end
    total++;
    if (ax0.tready !== 1'b1) begin
      bad++; $display("FAIL early_tready: got %b, want 1", ax0.tready);
    end
    clear_frame();
    re_mem[20] = 24'sd7;
    im_mem[20] = 24'sd24;
    push_expected({9'd20, 9'd100, 9'd0, 9'd21});
    send_frame(FFT_LEN, FFT_LEN - 1);
    wait_valid(20, cyc);
    check_published("after_early");
    ack_frame("after_early");
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_frame();
    re_mem[11] = 24'sd5; im_mem[11] = 24'sd12;
    push_expected({9'd11, 9'd13, 9'd0, 9'd1});
    send_frame(FFT_LEN, FFT_LEN - 1);
    wait_valid(20, cyc);
    clear_frame();
    re_mem[13] = 24'sd8; im_mem[13] = 24'sd15;
    push_expected({9'd13, 9'd11, 9'd0, 9'd1});
    send_frame(FFT_LEN, FFT_LEN - 1);
    repeat (8) @(posedge clk_50m);
    #1;
    total++;
    if (ax0.tready !== 1'b0 || fv0 !== 1'b1) begin
      bad++; $display("FAIL b2b_wait: tready=%b valid=%b, want 0/1", ax0.tready, fv0);
    end
    check_published("b2b_A");
    ack_frame("b2b_A");
    wait_valid(20, cyc);
    total++;
    if (fv0 !== 1'b1 || cyc != 2 || ax0.tready !== 1'b1) begin
      bad++; $display("FAIL b2b_release: valid=%b after %0d cycles tready=%b, want 1 after 2, tready 1",
                      fv0, cyc, ax0.tready);
    end
    check_published("b2b_B");
    ack_frame("b2b_B");
  endtask

  task automatic test_missing_tlast();
    int cyc, e0, m0;
    e0 = early_cnt;
    m0 = miss_cnt;
    clear_frame();
    re_mem[30] = 24'sd9; im_mem[30] = 24'sd40;
    push_expected({9'd30, 9'd0, 9'd29, 9'd31});
    send_frame(FFT_LEN, -1);
    total++;
    if (em0 !== 1'b1 || em1 !== 1'b1) begin
      bad++; $display("FAIL missing_pulse: got %b/%b after beat 1023, want 1/1", em0, em1);
    end
    wait_valid(20, cyc);
    total++;
    if (fv0 !== 1'b1 || cyc != 3 || miss_cnt - m0 != 1 || early_cnt - e0 != 0) begin
      bad++; $display("FAIL missing_publish: valid=%b cyc=%0d miss=%0d early=%0d, want 1/3/1/0",
                      fv0, cyc, miss_cnt - m0, early_cnt - e0);
    end
    check_published("missing");
    ack_frame("missing");
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    clear_frame();
    re_mem[50] = 24'sd100; im_mem[50] = 24'sd100;
    send_frame(300, -1);
    @(negedge clk_50m);
    rst_n = 1'b0;
    #1;
    total++;
    if (fv0 !== 1'b0 || ax0.tready !== 1'b0 || pp0 !== 32'd0 || pb0 !== 9'd0) begin
      bad++; $display("FAIL midreset_state: valid=%b tready=%b pp=%0d pb=%0d, want 0/0/0/0",
                      fv0, ax0.tready, pp0, pb0);
    end
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(posedge clk_50m);
    #1;
    total++;
    if (ax0.tready !== 1'b1 || fv0 !== 1'b0) begin
      bad++; $display("FAIL midreset_release: tready=%b valid=%b, want 1/0", ax0.tready, fv0);
    end
    clear_frame();
    re_mem[40] = 24'sd0; im_mem[40] = -24'sd30;
    push_expected({9'd40, 9'd50, 9'd0, 9'd39});
    send_frame(FFT_LEN, FFT_LEN - 1);
    wait_valid(20, cyc);
    total++;
    if (fv0 !== 1'b1 || cyc != 3) begin
      bad++; $display("FAIL midreset_latency: valid=%b after %0d cycles, want 1 after 3", fv0, cyc);
    end
    check_published("midreset");
    ack_frame("midreset");
  endtask

  initial begin
    test_reset();
    test_single_bin();
    test_saturation();
    test_tie_dc();
    test_early_tlast();
    test_back_to_back();
    test_missing_tlast();
    test_reset_mid_frame();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_spectrum_sink.md
Name: fft_spectrum_sink

Overview:
- Terminating end of the FFT output stream. Accepts the forward-FFT M_AXIS output ({Re,Im} per bin, framed by tlast).
- Computes per-bin power Re²+Im² for bins 0..FFT_LEN/2-1 and stores them in a double-buffered bin RAM.
- Tracks the peak bin and publishes completed frames to the display/analysis side through a valid/ack handshake plus a 1-cycle-latency random read port.
- Checks frame length against tlast and applies back-pressure to the FFT while the display still holds a frame.

Parameters:
FFT_LEN, 1024, bins per FFT frame; power of two, ≥8
FFT_RE_IM_WIDTH, 24, signed width of each of Re and Im
PWR_WIDTH, 32, stored power width
PWR_SHIFT, 14, right shift applied to the full-precision power before saturation

Ports:
clk_50m  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  FFT output valid
s_axis_tready  out  1  sink ready
s_axis_tdata  in  2*FFT_RE_IM_WIDTH  {Re[47:24],Im[23:0]}, two's complement
s_axis_tlast  in  1  last bin of frame
frame_valid  out  1  published frame available
frame_ack  in  1  reader releases published frame (single-cycle pulse)
rd_addr  in  log2(FFT_LEN/2)  bin index to read
rd_data  out  PWR_WIDTH  power of bin rd_addr in published bank
peak_bin  out  log2(FFT_LEN/2)  bin index of maximum power, published frame
peak_pwr  out  PWR_WIDTH  power at peak_bin
err_tlast_early  out  1  one-cycle pulse: tlast before bin FFT_LEN-1
err_tlast_missing  out  1  one-cycle pulse: bin FFT_LEN-1 accepted without tlast

Behaviour:
- Reset (async, rst_n=0): state FILL, bin counter 0, write bank 0, read bank 1, frame_valid=0, s_axis_tready=0 during reset then 1, rd_data=0, peak_bin=0, peak_pwr=0, err pulses 0, running max cleared.
- Beat accepted when s_axis_tvalid & s_axis_tready. Bin counter cnt increments per beat.
- s_axis_tready=1 only in FILL.
- Power pipeline (2 stages):
  - S1 registers Re² and Im² (signed squares, 2W bits each).
  - S2 computes sum (2W+1 bits), shifts right by PWR_SHIFT, saturates to all-ones if the result exceeds PWR_WIDTH bits, then writes RAM[write bank][cnt] when cnt < FFT_LEN/2.
  - Bins ≥ FFT_LEN/2 are squared but not stored.
- Peak tracking at S2 over bins 1..FFT_LEN/2-1 (DC excluded). Update only on strictly greater power, so ties keep the lowest index. Running max resets at every frame start.
- States:
  - FILL: accepting.
    - Beat with tlast & cnt==FFT_LEN-1 → DRAIN.
    - Beat with cnt==FFT_LEN-1 & !tlast → pulse err_tlast_missing, → DRAIN.
    - Beat with tlast & cnt<FFT_LEN-1 → pulse err_tlast_early, discard the frame (cnt=0, running max cleared, bank unchanged, nothing published), stay FILL.
  - DRAIN: 2 cycles for the pipeline to write the last stored bin and peak; then → WAIT if frame_valid=1, else → PUBLISH.
  - WAIT: hold; → PUBLISH in the cycle after frame_ack clears frame_valid.
  - PUBLISH (1 cycle): read bank ← write bank, write bank toggles, peak_bin/peak_pwr latched from the running max, frame_valid←1, cnt←0, → FILL.
- frame_ack clears frame_valid the next cycle. Ack with frame_valid=0 is ignored. Ack in the same cycle as PUBLISH: PUBLISH wins, frame_valid stays 1.
- Read port: rd_data registered, 1-cycle latency, always reads the read bank. Contents stay stable while frame_valid=1. After ack, contents stay stable until the next PUBLISH.
- Error pulses are independent of frame_valid and never stall the stream.
- Reset mid-frame: partial frame discarded, all state returns to reset values.

Test Plan:
1. Full frame, bin 5 = {Re=3, Im=-4}, all others 0, PWR_SHIFT=0 → frame_valid rises 3 cycles after the tlast beat (2 DRAIN + 1 PUBLISH); read addr 5 → rd_data=25 one cycle later; peak_bin=5, peak_pwr=25.
2. Saturation at defaults: bin 7 = {Re=-2^23, Im=-2^23} → power 2^47>>14 = 2^33 → rd_data=0xFFFFFFFF.
3. Tie and DC exclusion: bins 0, 3 and 9 each power 100, PWR_SHIFT=0 → peak_bin=3, peak_pwr=100.
4. Early tlast at cnt=500 → err_tlast_early pulses once; no frame published; the next good frame publishes normally with its own data.
5. Back-pressure: publish frame A, no ack, stream frame B → after B's tlast s_axis_tready=0 (WAIT); pulse frame_ack → frame B published 2 cycles later and tready returns to 1; reads return B data.
6. Missing tlast: 1024 beats with no tlast → err_tlast_missing pulses on beat 1023 and the frame is still published. Separately, assert rst_n low mid-frame → frame_valid=0, tready=1 after release, and the next frame is correct.
